// File: rtl/pmu_pwr_seq.sv
// Power-management sequencer for a switchable core domain.
// Walks the domain down (clock off, isolate, reset, power off) on a sleep
// request, and back up in reverse order on a wake event, with per-step hold
// times and a bounded wait for the power-switch acknowledge.
module pmu_pwr_seq #(
    parameter int STEP_DLY = 3,
    parameter int ACK_TO   = 64
) (
    input  logic       i_oclk,
    input  logic       i_orstn,
    input  logic       i_sleep_req,
    input  logic       i_wake_evt,
    input  logic       i_pwr_ack,
    output logic       o_clk_en,
    output logic       o_iso_en,
    output logic       o_rst_n,
    output logic       o_pwr_en,
    output logic       o_sleep_ack,
    output logic [3:0] o_state,
    output logic       o_err
);

    typedef enum logic [3:0] {
        RUN     = 4'd0,
        CLK_OFF = 4'd1,
        ISO_ON  = 4'd2,
        RST_ON  = 4'd3,
        PWR_OFF = 4'd4,
        SLEEP   = 4'd5,
        PWR_ON  = 4'd6,
        RST_OFF = 4'd7,
        ISO_OFF = 4'd8,
        CLK_ON  = 4'd9
    } state_t;

    localparam logic [7:0] STEP_LAST = 8'(STEP_DLY - 1);
    localparam logic [7:0] ACK_LAST  = 8'(ACK_TO - 1);

    state_t     state;
    state_t     next_state;
    logic [7:0] cnt;
    logic       err;
    logic       set_err;
    logic       step_done;
    logic       ack_timeout;
    logic       abort_req;

    // A step is finished on the edge where it has been held STEP_DLY cycles.
    assign step_done   = (cnt == STEP_LAST);
    assign ack_timeout = (cnt == ACK_LAST);
    // Sleep is abandoned when the request drops or a wake event shows up.
    assign abort_req   = !i_sleep_req || i_wake_evt;

    // State register; unused codes fall back to RUN through next_state.
    always_ff @(posedge i_oclk) begin
        if (!i_orstn) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Residency counter: restarts on every state change, saturates at 255.
    always_ff @(posedge i_oclk) begin
        if (!i_orstn) begin
            cnt <= 8'd0;
        end else if (next_state != state) begin
            cnt <= 8'd0;
        end else if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
        end
    end

    // Sticky acknowledge-timeout flag, cleared only by reset.
    always_ff @(posedge i_oclk) begin
        if (!i_orstn) begin
            err <= 1'b0;
        end else if (set_err) begin
            err <= 1'b1;
        end
    end

    // Next-state logic: aborts beat step advance; power states wait on ack.
    always_comb begin
        next_state = state;
        set_err    = 1'b0;
        case (state)
            RUN: begin
                if (i_sleep_req && !i_wake_evt) next_state = CLK_OFF;
            end
            CLK_OFF: begin
                if (abort_req)      next_state = CLK_ON;
                else if (step_done) next_state = ISO_ON;
            end
            ISO_ON: begin
                if (abort_req)      next_state = ISO_OFF;
                else if (step_done) next_state = RST_ON;
            end
            RST_ON: begin
                if (abort_req)      next_state = RST_OFF;
                else if (step_done) next_state = PWR_OFF;
            end
            PWR_OFF: begin
                if (!i_pwr_ack) begin
                    next_state = SLEEP;
                end else if (ack_timeout) begin
                    next_state = SLEEP;
                    set_err    = 1'b1;
                end
            end
            SLEEP: begin
                if (abort_req) next_state = PWR_ON;
            end
            PWR_ON: begin
                if (i_pwr_ack) begin
                    next_state = RST_OFF;
                end else if (ack_timeout) begin
                    next_state = RST_OFF;
                    set_err    = 1'b1;
                end
            end
            RST_OFF: begin
                if (step_done) next_state = ISO_OFF;
            end
            ISO_OFF: begin
                if (step_done) next_state = CLK_ON;
            end
            CLK_ON: begin
                if (step_done) next_state = RUN;
            end
            default: next_state = RUN;
        endcase
    end

    // Moore output decode straight from the state register.
    always_comb begin
        o_clk_en    = 1'b1;
        o_iso_en    = 1'b0;
        o_rst_n     = 1'b1;
        o_pwr_en    = 1'b1;
        o_sleep_ack = 1'b0;
        case (state)
            CLK_OFF: begin
                o_clk_en = 1'b0;
            end
            ISO_ON: begin
                o_clk_en = 1'b0;
                o_iso_en = 1'b1;
            end
            RST_ON: begin
                o_clk_en = 1'b0;
                o_iso_en = 1'b1;
                o_rst_n  = 1'b0;
            end
            PWR_OFF: begin
                o_clk_en = 1'b0;
                o_iso_en = 1'b1;
                o_rst_n  = 1'b0;
                o_pwr_en = 1'b0;
            end
            SLEEP: begin
                o_clk_en    = 1'b0;
                o_iso_en    = 1'b1;
                o_rst_n     = 1'b0;
                o_pwr_en    = 1'b0;
                o_sleep_ack = 1'b1;
            end
            PWR_ON: begin
                o_clk_en = 1'b0;
                o_iso_en = 1'b1;
                o_rst_n  = 1'b0;
            end
            RST_OFF: begin
                o_clk_en = 1'b0;
                o_iso_en = 1'b1;
            end
            ISO_OFF: begin
                o_clk_en = 1'b0;
            end
            default: begin
                o_clk_en = 1'b1;
            end
        endcase
    end

    assign o_state = state;
    assign o_err   = err;

endmodule

// File: tb/tb_pmu_pwr_seq.sv
// Self-checking bench for pmu_pwr_seq (STEP_DLY=3, ACK_TO=8).
// Stimulus is a table of run-length segments; each driven cycle pushes the
// expected state/err into a queue that a checker pops one edge later.
module tb_pmu_pwr_seq;

    logic       i_oclk;
    logic       i_orstn;
    logic       i_sleep_req;
    logic       i_wake_evt;
    logic       i_pwr_ack;
    logic       o_clk_en;
    logic       o_iso_en;
    logic       o_rst_n;
    logic       o_pwr_en;
    logic       o_sleep_ack;
    logic [3:0] o_state;
    logic       o_err;

    typedef struct {
        logic [3:0] st;
        logic       er;
    } exp_t;

    typedef struct {
        logic       rstn;
        logic       sleep;
        logic       wake;
        logic       ack_force;
        logic       ack_val;
        int         ack_lat;
        logic [3:0] st;
        logic       er;
        int         n;
    } vec_t;

    exp_t       exp_q[$];
    vec_t       vecs[$];
    logic [4:0] out_table [0:9];
    logic [7:0] hist;
    int         checks;
    int         passed;

    pmu_pwr_seq #(
        .STEP_DLY(3),
        .ACK_TO  (8)
    ) dut (
        .i_oclk     (i_oclk),
        .i_orstn    (i_orstn),
        .i_sleep_req(i_sleep_req),
        .i_wake_evt (i_wake_evt),
        .i_pwr_ack  (i_pwr_ack),
        .o_clk_en   (o_clk_en),
        .o_iso_en   (o_iso_en),
        .o_rst_n    (o_rst_n),
        .o_pwr_en   (o_pwr_en),
        .o_sleep_ack(o_sleep_ack),
        .o_state    (o_state),
        .o_err      (o_err)
    );

    // Free-running 10 ns clock.
    initial begin
        i_oclk = 1'b0;
        forever #5 i_oclk = ~i_oclk;
    end

    task automatic checkValue(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act === req) passed++;
        else $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    endtask

    task automatic checkOutput(input exp_t e);
        checkValue("state", {4'b0, o_state}, {4'b0, e.st});
        checkValue("outputs", {3'b0, o_clk_en, o_iso_en, o_rst_n, o_pwr_en, o_sleep_ack},
                   {3'b0, out_table[e.st]});
        checkValue("err", {7'b0, o_err}, {7'b0, e.er});
    endtask

    // Drive one cycle at the falling edge and queue what the next edge must produce.
    // The power switch is modelled as o_pwr_en delayed by lat falling edges, or forced.
    task automatic applyStimulus(input logic rstn, input logic sleep, input logic wake,
                                 input logic ack_force, input logic ack_val, input int lat,
                                 input logic [3:0] st, input logic er);
        exp_t e;
        @(negedge i_oclk);
        hist        = {hist[6:0], o_pwr_en};
        i_pwr_ack   = ack_force ? ack_val : hist[lat];
        i_orstn     = rstn;
        i_sleep_req = sleep;
        i_wake_evt  = wake;
        e.st = st;
        e.er = er;
        exp_q.push_back(e);
    endtask

    task automatic runSeg(input vec_t v);
        for (int k = 0; k < v.n; k++)
            applyStimulus(v.rstn, v.sleep, v.wake, v.ack_force, v.ack_val, v.ack_lat, v.st, v.er);
    endtask

    task automatic addVec(input logic rstn, input logic sleep, input logic wake,
                          input logic af, input logic av, input int lat,
                          input logic [3:0] st, input logic er, input int n);
        vec_t v;
        v.rstn = rstn; v.sleep = sleep; v.wake = wake;
        v.ack_force = af; v.ack_val = av; v.ack_lat = lat;
        v.st = st; v.er = er; v.n = n;
        vecs.push_back(v);
    endtask

    // Compare DUT against the oldest expectation just after each rising edge.
    always @(posedge i_oclk) begin
        #1;
        if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end

    initial begin
        checks = 0;
        passed = 0;
        hist   = 8'hFF;
        i_orstn = 1'b0; i_sleep_req = 1'b0; i_wake_evt = 1'b0; i_pwr_ack = 1'b1;
        // clk_en, iso_en, rst_n, pwr_en, sleep_ack for states 0..9
        out_table[0] = 5'b10110; out_table[1] = 5'b00110; out_table[2] = 5'b01110;
        out_table[3] = 5'b01010; out_table[4] = 5'b01000; out_table[5] = 5'b01001;
        out_table[6] = 5'b01010; out_table[7] = 5'b01110; out_table[8] = 5'b00110;
        out_table[9] = 5'b10110;

        // reset
        addVec(0,0,0, 0,0,1, 0,0, 2);
        // full sleep, ack follows pwr_en one edge late
        addVec(1,1,0, 0,0,1, 1,0, 3); addVec(1,1,0, 0,0,1, 2,0, 3);
        addVec(1,1,0, 0,0,1, 3,0, 3); addVec(1,1,0, 0,0,1, 4,0, 2);
        addVec(1,1,0, 0,0,1, 5,0, 2);
        // wake: one-cycle wake event, ack rises two edges late
        addVec(1,0,1, 0,0,2, 6,0, 1); addVec(1,0,0, 0,0,2, 6,0, 2);
        addVec(1,0,0, 0,0,2, 7,0, 3); addVec(1,0,0, 0,0,2, 8,0, 3);
        addVec(1,0,0, 0,0,2, 9,0, 3); addVec(1,0,0, 0,0,2, 0,0, 2);
        // abort during second cycle of ISO_ON
        addVec(1,1,0, 0,0,1, 1,0, 3); addVec(1,1,0, 0,0,1, 2,0, 2);
        addVec(1,0,0, 0,0,1, 8,0, 3); addVec(1,0,0, 0,0,1, 9,0, 3);
        addVec(1,0,0, 0,0,1, 0,0, 2);
        // PWR_OFF timeout with ack stuck high
        addVec(1,1,0, 1,1,1, 1,0, 3); addVec(1,1,0, 1,1,1, 2,0, 3);
        addVec(1,1,0, 1,1,1, 3,0, 3); addVec(1,1,0, 1,1,1, 4,0, 8);
        addVec(1,1,0, 1,1,1, 5,1, 1);
        // wake with sleep still requested: err stays, RUN re-enters CLK_OFF
        addVec(1,1,1, 0,0,2, 6,1, 1); addVec(1,1,0, 0,0,2, 6,1, 2);
        addVec(1,1,0, 0,0,2, 7,1, 3); addVec(1,1,0, 0,0,2, 8,1, 3);
        addVec(1,1,0, 0,0,2, 9,1, 3); addVec(1,1,0, 0,0,2, 0,1, 1);
        addVec(1,1,0, 0,0,1, 1,1, 3); addVec(1,1,0, 0,0,1, 2,1, 3);
        addVec(1,1,0, 0,0,1, 3,1, 3); addVec(1,1,0, 0,0,1, 4,1, 1);
        // reset for one cycle in PWR_OFF, then a clean full sleep
        addVec(0,1,0, 0,0,1, 0,0, 1);
        addVec(1,1,0, 0,0,1, 1,0, 3); addVec(1,1,0, 0,0,1, 2,0, 3);
        addVec(1,1,0, 0,0,1, 3,0, 3); addVec(1,1,0, 0,0,1, 4,0, 2);
        addVec(1,1,0, 0,0,1, 5,0, 1);
        addVec(1,0,1, 0,0,2, 6,0, 1); addVec(1,0,0, 0,0,2, 6,0, 2);
        addVec(1,0,0, 0,0,2, 7,0, 3); addVec(1,0,0, 0,0,2, 8,0, 3);
        addVec(1,0,0, 0,0,2, 9,0, 3); addVec(1,0,0, 0,0,2, 0,0, 1);
        // simultaneous sleep and wake keep RUN
        addVec(1,1,1, 0,0,1, 0,0, 10);
        // wake aborts CLK_OFF; sleep drop aborts RST_ON
        addVec(1,1,0, 0,0,1, 1,0, 1); addVec(1,1,1, 0,0,1, 9,0, 3);
        addVec(1,1,1, 0,0,1, 0,0, 2);
        addVec(1,1,0, 0,0,1, 1,0, 3); addVec(1,1,0, 0,0,1, 2,0, 3);
        addVec(1,1,0, 0,0,1, 3,0, 1); addVec(1,0,0, 0,0,1, 7,0, 3);
        addVec(1,0,0, 0,0,1, 8,0, 3); addVec(1,0,0, 0,0,1, 9,0, 3);
        addVec(1,0,0, 0,0,1, 0,0, 2);

        foreach (vecs[i]) runSeg(vecs[i]);

        // Reset asserted between edges must not disturb outputs until the edge.
        applyStimulus(1, 1, 0, 0, 0, 1, 1, 0);
        applyStimulus(0, 1, 0, 0, 0, 1, 0, 0);
        #2;
        checkValue("no_async_reset_state", {4'b0, o_state}, 8'd1);
        checkValue("no_async_reset_clk_en", {7'b0, o_clk_en}, 8'd0);
        for (int k = 0; k < 3; k++) applyStimulus(0, 1, 0, 0, 0, 1, 0, 0);

        // PWR_ON timeout: ack never returns, sequence continues with err set.
        for (int k = 0; k < 3; k++) applyStimulus(1, 1, 0, 0, 0, 1, 1, 0);
        for (int k = 0; k < 3; k++) applyStimulus(1, 1, 0, 0, 0, 1, 2, 0);
        for (int k = 0; k < 3; k++) applyStimulus(1, 1, 0, 0, 0, 1, 3, 0);
        for (int k = 0; k < 2; k++) applyStimulus(1, 1, 0, 0, 0, 1, 4, 0);
        applyStimulus(1, 1, 0, 0, 0, 1, 5, 0);
        applyStimulus(1, 0, 1, 1, 0, 1, 6, 0);
        for (int k = 0; k < 7; k++) applyStimulus(1, 0, 0, 1, 0, 1, 6, 0);
        for (int k = 0; k < 3; k++) applyStimulus(1, 0, 0, 1, 0, 1, 7, 1);
        for (int k = 0; k < 3; k++) applyStimulus(1, 0, 0, 1, 0, 1, 8, 1);
        for (int k = 0; k < 3; k++) applyStimulus(1, 0, 0, 1, 0, 1, 9, 1);
        for (int k = 0; k < 2; k++) applyStimulus(1, 0, 0, 1, 0, 1, 0, 1);

        repeat (2) @(posedge i_oclk);
        #2;
        checkValue("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
